// File: rtl/bin2bcd_pkg.sv
// -----------------------------------------------------------------------------
// bin2bcd_pkg
// Shared definitions for the binary-to-BCD streamer.
//   - state_e   : FSM state encoding (IDLE, CONVERT, EMIT)
//   - BCD_NIB_W : width of one BCD digit
//   - cnt_w()   : counter width helper (at least one bit)
// Optional feature macro used by the top: BIN2BCD_LZS_EN
// -----------------------------------------------------------------------------
package bin2bcd_pkg;

    localparam int BCD_NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        EMIT    = 2'd2
    } state_e;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bin2bcd_streamer_add3.sv
// -----------------------------------------------------------------------------
// bcd_add3
// Combinational double-dabble correction cell: nibbles of 5 or more get +3 so
// that the following left shift carries correctly into the next BCD digit.
// Ports:
//   i_nib : BCD nibble before correction
//   o_nib : corrected nibble
// -----------------------------------------------------------------------------
module bcd_add3
    import bin2bcd_pkg::*;
(
    input  logic [BCD_NIB_W-1:0] i_nib,
    output logic [BCD_NIB_W-1:0] o_nib
);

    assign o_nib = (i_nib >= 4'd5) ? (i_nib + 4'd3) : i_nib;

endmodule

// File: rtl/bin2bcd_streamer.sv
// -----------------------------------------------------------------------------
// bin2bcd_streamer
// Accepts one unsigned binary word, converts it to BCD with serial
// double-dabble (one bit per clock) and streams the digits MSD-first, one
// nibble per handshake, with first/last framing.
// Optional feature: define BIN2BCD_LZS_EN for leading-zero suppression
// (at least one digit is always emitted).
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid never depends combinationally on ready, and while valid is high
// and ready low the payload (digit/first/last) holds stable.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   i_in_valid    : i_in_data valid
//   o_in_ready    : block can accept a word (IDLE only)
//   i_in_data     : unsigned binary word
//   o_out_valid   : o_out_digit valid
//   i_out_ready   : consumer takes the digit
//   o_out_digit   : BCD digit 0..9
//   o_out_first   : first digit of the number
//   o_out_last    : last digit (LSD) of the number
//   o_dbg_state   : current FSM state (debug)
// -----------------------------------------------------------------------------
module bin2bcd_streamer
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [BIN_W-1:0] i_in_data,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [3:0]       o_out_digit,
    output logic             o_out_first,
    output logic             o_out_last,
    output logic [1:0]       o_dbg_state
);

    localparam int BCD_W = BCD_NIB_W * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int BC_W  = cnt_w(BIN_W);
    localparam int DI_W  = cnt_w(DIGITS);

    localparam logic [1:0] S_IDLE    = 2'(IDLE);
    localparam logic [1:0] S_CONVERT = 2'(CONVERT);
    localparam logic [1:0] S_EMIT    = 2'(EMIT);

    // The largest input must fit in DIGITS decimal digits.
    if (64'(10) ** DIGITS <= (64'(1) << BIN_W) - 64'(1)) begin : g_bad_cfg
        $error("bin2bcd_streamer: DIGITS too small for BIN_W");
    end

    logic [1:0]       r_state;
    logic [SR_W-1:0]  r_sr;        // {bcd, bin}
    logic [BC_W-1:0]  r_bit_cnt;
    logic [DI_W-1:0]  r_dig_idx;
    logic             r_first;

    logic [BCD_W-1:0] w_bcd_adj;
    logic [SR_W-1:0]  w_sr_shift;
    logic [DI_W-1:0]  w_start_idx;
    logic             w_out_valid;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .i_nib (r_sr[BIN_W + g*BCD_NIB_W +: BCD_NIB_W]),
            .o_nib (w_bcd_adj[g*BCD_NIB_W +: BCD_NIB_W])
        );
    end

    assign w_sr_shift = {w_bcd_adj, r_sr[BIN_W-1:0]} << 1;

    // Start index is computed from the value the final shift produces, so the
    // first digit is ready on the same edge that enters EMIT.
`ifdef BIN2BCD_LZS_EN
    always_comb begin
        w_start_idx = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (w_sr_shift[BIN_W + k*BCD_NIB_W +: BCD_NIB_W] != '0) begin
                w_start_idx = DI_W'(k);
            end
        end
    end
`else
    assign w_start_idx = DI_W'(DIGITS - 1);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_sr      <= '0;
            r_bit_cnt <= '0;
            r_dig_idx <= '0;
            r_first   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_in_valid) begin
                        r_sr      <= {{BCD_W{1'b0}}, i_in_data};
                        r_bit_cnt <= BC_W'(BIN_W - 1);
                        r_state   <= S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    r_sr      <= w_sr_shift;
                    r_bit_cnt <= r_bit_cnt - 1'b1;
                    if (r_bit_cnt == '0) begin
                        r_state   <= S_EMIT;
                        r_dig_idx <= w_start_idx;
                        r_first   <= 1'b1;
                    end
                end
                S_EMIT: begin
                    if (i_out_ready) begin
                        r_first   <= 1'b0;
                        r_dig_idx <= r_dig_idx - 1'b1;
                        if (r_dig_idx == '0) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_out_valid = (r_state == S_EMIT);
    assign o_in_ready  = (r_state == S_IDLE);
    assign o_out_valid = w_out_valid;
    assign o_out_digit = w_out_valid ? r_sr[BIN_W + 4*int'(r_dig_idx) +: 4] : 4'd0;
    assign o_out_first = w_out_valid & r_first;
    assign o_out_last  = w_out_valid & (r_dig_idx == '0);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bin2bcd_streamer.sv
// -----------------------------------------------------------------------------
// tb_bin2bcd_streamer
// Self-checking bench for bin2bcd_streamer (BIN_W=16, DIGITS=5). Honours
// BIN2BCD_LZS_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_bin2bcd_streamer;

    localparam int BIN_W  = 16;
    localparam int DIGITS = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_in_valid;
    logic        o_in_ready;
    logic [15:0] i_in_data;
    logic        o_out_valid;
    logic        i_out_ready;
    logic [3:0]  o_out_digit;
    logic        o_out_first;
    logic        o_out_last;
    logic [1:0]  o_dbg_state;

    bin2bcd_streamer #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_in_data   (i_in_data),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_out_digit (o_out_digit),
        .o_out_first (o_out_first),
        .o_out_last  (o_out_last),
        .o_dbg_state (o_dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic [19:0] bcd;
        bit          stall;
    } vec_t;

    vec_t       vecs[6];
    logic [3:0] exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         mod_res;
    bit         mod_div;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: decimal digits by plain division.
    function automatic logic [19:0] ref_bcd(input int unsigned v);
        logic [19:0] b;
        int unsigned x;
        b = '0;
        x = v;
        for (int k = 0; k < DIGITS; k++) begin
            b[k*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return b;
    endfunction

    // Expected digit stream, MSD first, optionally without leading zeros.
    function automatic void build_q(input logic [19:0] bcd);
        int top;
        top = DIGITS - 1;
`ifdef BIN2BCD_LZS_EN
        while (top > 0 && bcd[top*4 +: 4] == 4'd0) top--;
`endif
        exp_q.delete();
        for (int k = top; k >= 0; k--) exp_q.push_back(bcd[k*4 +: 4]);
    endfunction

    // Send one word and consume its digits. abort_after >= 0 asserts reset
    // while that digit index is on the output.
    task automatic run_word(input logic [15:0] d, input bit stall, input bit hold,
                            input int abort_after);
        int cyc;
        int lat;
        int n;
        bit hs;
        i_in_data  = d;
        i_in_valid = 1'b1;
        cyc = 0;
        while (!o_in_ready && cyc < 200) begin
            tick();
            cyc++;
        end
        check("in_ready_before_accept", 32'(o_in_ready), 32'd1);
        tick();
        if (!hold) i_in_valid = 1'b0;
        check("in_ready_after_accept", 32'(o_in_ready), 32'd0);
        lat = 0;
        while (!o_out_valid && lat < 100) begin
            check("in_ready_convert", 32'(o_in_ready), 32'd0);
            tick();
            lat++;
        end
        check("valid_latency", 32'(lat), 32'(BIN_W));
        n = 0;
        mod_res = 0;
        foreach (exp_q[k]) begin
            if (n == abort_after) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                check("abort_next_cycle",
                      {o_out_valid, o_in_ready, o_out_digit, o_out_first, o_out_last},
                      {1'b0, 1'b1, 4'd0, 1'b0, 1'b0});
                tick();
                check("abort_stays_idle", {o_out_valid, o_in_ready}, 2'b01);
                i_out_ready = 1'b0;
                return;
            end
            hs = 1'b0;
            cyc = 0;
            while (!hs && cyc < 60) begin
                i_out_ready = (!stall || cyc >= 20) ? 1'b1 : ($urandom_range(0, 2) == 0);
                check("beat",
                      {o_out_valid, o_in_ready, o_out_digit, o_out_first, o_out_last},
                      {1'b1, 1'b0, exp_q[k], (k == 0), (k == exp_q.size() - 1)});
                hs = o_out_valid && i_out_ready;
                if (hs) mod_res = o_out_first ? (int'(o_out_digit) % 3)
                                              : ((mod_res * 10 + int'(o_out_digit)) % 3);
                tick();
                cyc++;
            end
            if (!hs) check("handshake_timeout", 32'd0, 32'd1);
            n++;
        end
        i_out_ready = 1'b0;
        check("frame_end", {o_out_valid, o_in_ready}, 2'b01);
        mod_div = (mod_res == 0);
    endtask

    initial begin
        vecs[0] = '{data: 16'd12345, bcd: 20'h12345, stall: 1'b0};
        vecs[1] = '{data: 16'd0,     bcd: 20'h00000, stall: 1'b0};
        vecs[2] = '{data: 16'd65535, bcd: 20'h65535, stall: 1'b0};
        vecs[3] = '{data: 16'd907,   bcd: 20'h00907, stall: 1'b0};
        vecs[4] = '{data: 16'd4021,  bcd: 20'h04021, stall: 1'b1};
        vecs[5] = '{data: 16'd9,     bcd: 20'h00009, stall: 1'b1};

        reset       = 1'b1;
        i_in_valid  = 1'b0;
        i_in_data   = '0;
        i_out_ready = 1'b0;
        repeat (3) tick();
        check("reset_state",
              {o_in_ready, o_out_valid, o_out_digit, o_out_first, o_out_last},
              {1'b1, 1'b0, 4'd0, 1'b0, 1'b0});
        reset = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            build_q(vecs[i].bcd);
            run_word(vecs[i].data, vecs[i].stall, 1'b0, -1);
        end

        // Reset while the third digit is presented, then a clean word.
        build_q(20'h12345);
        run_word(16'd12345, 1'b0, 1'b0, 2);
        build_q(20'h00042);
        run_word(16'd42, 1'b0, 1'b0, -1);

        // Back-to-back with in_valid held high; digits feed a mod-3 checker.
        build_q(20'h12345);
        run_word(16'd12345, 1'b0, 1'b1, -1);
        check("div3_12345", 32'(mod_div), 32'd1);
        build_q(20'h12346);
        run_word(16'd12346, 1'b0, 1'b1, -1);
        i_in_valid = 1'b0;
        check("div3_12346", 32'(mod_div), 32'd0);
        tick();
        check("no_reaccept", {o_out_valid, o_in_ready}, 2'b01);

        // Random words against the arithmetic reference.
        for (int i = 0; i < 40; i++) begin
            logic [15:0] v;
            v = 16'($urandom_range(0, 65535));
            build_q(ref_bcd(32'(v)));
            run_word(v, 1'($urandom_range(0, 1)), 1'b0, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
